// File: rtl/mem_arbiter.sv
// mem_arbiter: round-robin arbiter sharing one synchronous RAM between NREQ
// bus masters. Every transaction takes four cycles: IDLE -> ACCESS -> CAPTURE -> ACK.
// Build option: define MEM_ARB_LOCK_EN to let a master keep its grant
// across back-to-back accesses by holding lock during its ACK cycle.
module mem_arbiter #(
  parameter int NREQ = 2,
  parameter int AW   = 16,
  parameter int DW   = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [NREQ-1:0]      req,
  input  logic [NREQ-1:0]      req_we,
  input  logic [NREQ*AW-1:0]   req_addr,
  input  logic [NREQ*DW-1:0]   req_wdata,
  input  logic [NREQ-1:0]      lock,
  output logic [NREQ-1:0]      ack,
  output logic [DW-1:0]        rdata,
  output logic [1:0]           gnt_id,
  output logic                 busy,
  output logic [AW-1:0]        mem_addr,
  output logic [DW-1:0]        mem_do,
  output logic                 mem_we,
  input  logic [DW-1:0]        mem_di
);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_ACCESS  = 2'd1,
    S_CAPTURE = 2'd2,
    S_ACK     = 2'd3
  } state_t;

  state_t            state_q, state_d;
  logic [NREQ-1:0]   ack_q, ack_d;
  logic [DW-1:0]     rdata_q, rdata_d;
  logic [1:0]        gnt_q, gnt_d;
  logic              busy_q, busy_d;
  logic [AW-1:0]     mem_addr_q, mem_addr_d;
  logic [DW-1:0]     mem_do_q, mem_do_d;
  logic              mem_we_q, mem_we_d;
  logic              we_q, we_d;
  logic [1:0]        rr_q, rr_d;

  // Requests widened to 4 bits so a 2-bit index is always in range.
  logic [3:0]        req_x;
  assign req_x = 4'(req);

`ifdef MEM_ARB_LOCK_EN
  logic              lock_q, lock_d;
  logic [3:0]        lock_x;
  assign lock_x = 4'(lock);
`else
  logic              lock_unused;
  assign lock_unused = ^lock;
`endif

  // Round-robin search: first requester strictly after rr, wrapping modulo NREQ.
  logic [1:0] rr_win;
  logic [1:0] cand;
  always_comb begin
    rr_win = '0;
    cand   = '0;
    for (int k = NREQ; k >= 1; k--) begin
      cand = 2'((32'(rr_q) + 32'(k)) % NREQ);
      if (req_x[cand]) rr_win = cand;
    end
  end

  // Final winner: a held lock on a still-requesting master beats round-robin.
  logic [1:0] win;
  always_comb begin
    win = rr_win;
`ifdef MEM_ARB_LOCK_EN
    if (lock_q && req_x[gnt_q]) win = gnt_q;
`endif
  end

  // Mux the winning master's command fields.
  logic              sel_we;
  logic [AW-1:0]     sel_addr;
  logic [DW-1:0]     sel_wdata;
  always_comb begin
    sel_we    = 1'b0;
    sel_addr  = '0;
    sel_wdata = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (win == 2'(i)) begin
        sel_we    = req_we[i];
        sel_addr  = req_addr[i*AW +: AW];
        sel_wdata = req_wdata[i*DW +: DW];
      end
    end
  end

  // Next-state and registered-output logic for the transaction sequencer.
  always_comb begin
    state_d    = state_q;
    ack_d      = '0;
    rdata_d    = rdata_q;
    gnt_d      = gnt_q;
    mem_addr_d = mem_addr_q;
    mem_do_d   = mem_do_q;
    mem_we_d   = 1'b0;
    we_d       = we_q;
    rr_d       = rr_q;
`ifdef MEM_ARB_LOCK_EN
    lock_d     = lock_q;
`endif
    case (state_q)
      S_IDLE: begin
`ifdef MEM_ARB_LOCK_EN
        // A lock is good for exactly one re-grant decision.
        lock_d = 1'b0;
`endif
        if (|req) begin
          gnt_d      = win;
          mem_addr_d = sel_addr;
          mem_do_d   = sel_wdata;
          we_d       = sel_we;
          mem_we_d   = sel_we;
          state_d    = S_ACCESS;
        end
      end
      S_ACCESS: begin
        state_d = S_CAPTURE;
      end
      S_CAPTURE: begin
        if (!we_q) rdata_d = mem_di;
        for (int i = 0; i < NREQ; i++) ack_d[i] = (gnt_q == 2'(i));
        state_d = S_ACK;
      end
      S_ACK: begin
        rr_d    = gnt_q;
`ifdef MEM_ARB_LOCK_EN
        lock_d  = lock_x[gnt_q];
`endif
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
    busy_d = (state_d != S_IDLE);
  end

  // State and output registers; reset wins over every state.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= S_IDLE;
      ack_q      <= '0;
      rdata_q    <= '0;
      gnt_q      <= '0;
      busy_q     <= 1'b0;
      mem_addr_q <= '0;
      mem_do_q   <= '0;
      mem_we_q   <= 1'b0;
      we_q       <= 1'b0;
      rr_q       <= 2'(NREQ - 1);
`ifdef MEM_ARB_LOCK_EN
      lock_q     <= 1'b0;
`endif
    end else begin
      state_q    <= state_d;
      ack_q      <= ack_d;
      rdata_q    <= rdata_d;
      gnt_q      <= gnt_d;
      busy_q     <= busy_d;
      mem_addr_q <= mem_addr_d;
      mem_do_q   <= mem_do_d;
      mem_we_q   <= mem_we_d;
      we_q       <= we_d;
      rr_q       <= rr_d;
`ifdef MEM_ARB_LOCK_EN
      lock_q     <= lock_d;
`endif
    end
  end

  assign ack      = ack_q;
  assign rdata    = rdata_q;
  assign gnt_id   = gnt_q;
  assign busy     = busy_q;
  assign mem_addr = mem_addr_q;
  assign mem_do   = mem_do_q;
  assign mem_we   = mem_we_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter with three masters and a behavioural sync RAM.
module tb_mem_arbiter;
  localparam int NREQ = 3;
  localparam int AW   = 16;
  localparam int DW   = 8;

  logic                 clk = 1'b0;
  logic                 rst;
  logic [NREQ-1:0]      req, req_we, lock;
  logic [NREQ*AW-1:0]   req_addr;
  logic [NREQ*DW-1:0]   req_wdata;
  logic [NREQ-1:0]      ack;
  logic [DW-1:0]        rdata;
  logic [1:0]           gnt_id;
  logic                 busy;
  logic [AW-1:0]        mem_addr;
  logic [DW-1:0]        mem_do;
  logic                 mem_we;
  logic [DW-1:0]        mem_di;

  int n_tests = 0;
  int n_fail  = 0;

  mem_arbiter #(.NREQ(NREQ), .AW(AW), .DW(DW)) dut (
    .clk(clk), .rst(rst), .req(req), .req_we(req_we), .req_addr(req_addr),
    .req_wdata(req_wdata), .lock(lock), .ack(ack), .rdata(rdata),
    .gnt_id(gnt_id), .busy(busy), .mem_addr(mem_addr), .mem_do(mem_do),
    .mem_we(mem_we), .mem_di(mem_di)
  );

  always #5 clk = ~clk;

  // Synchronous RAM with a backdoor port for preloading.
  logic [7:0]  ram [0:65535];
  logic        bd_we = 1'b0;
  logic [15:0] bd_addr = '0;
  logic [7:0]  bd_data = '0;
  always @(posedge clk) begin
    if (mem_we) ram[mem_addr] <= mem_do;
    else if (bd_we) ram[bd_addr] <= bd_data;
    mem_di <= ram[mem_addr];
  end

  task automatic poke(input logic [15:0] a, input logic [7:0] d);
    bd_addr = a; bd_data = d; bd_we = 1'b1;
    @(posedge clk); #1;
    bd_we = 1'b0;
  endtask

  // One transaction for master m; returns edges to ack and what was seen then.
  task automatic do_txn(input int m, input logic we, input logic [15:0] a, input logic [7:0] wd,
                        output int edges, output logic [2:0] ackv, output logic [1:0] gid,
                        output logic [7:0] rd, output int wecnt);
    req_we[m] = we; req_addr[m*AW +: AW] = a; req_wdata[m*DW +: DW] = wd; req[m] = 1'b1;
    edges = 0; ackv = '0; gid = '0; rd = '0; wecnt = 0;
    for (int k = 0; k < 20; k++) begin
      @(posedge clk); edges++;
      @(negedge clk);
      if (mem_we) wecnt++;
      if (ack != 0) begin ackv = ack; gid = gnt_id; rd = rdata; break; end
    end
    req[m] = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic test_reset;
    rst = 1'b1; req = '0; req_we = '0; lock = '0; req_addr = '0; req_wdata = '0;
    poke(16'h0010, 8'hA5);
    poke(16'h0100, 8'h11); poke(16'h0200, 8'h22); poke(16'h0300, 8'h33);
    poke(16'h0040, 8'hC0); poke(16'h0041, 8'hC1); poke(16'h0042, 8'hC2); poke(16'h0043, 8'hC3);
    poke(16'h0500, 8'h77); poke(16'h0600, 8'h66);
    @(negedge clk);
    n_tests++; if (ack !== 3'b000) begin n_fail++; $display("FAIL reset_ack got=%b exp=000", ack); end
    n_tests++; if (mem_we !== 1'b0) begin n_fail++; $display("FAIL reset_mem_we got=%b exp=0", mem_we); end
    n_tests++; if (mem_addr !== 16'h0) begin n_fail++; $display("FAIL reset_mem_addr got=%h exp=0", mem_addr); end
    n_tests++; if (mem_do !== 8'h0) begin n_fail++; $display("FAIL reset_mem_do got=%h exp=0", mem_do); end
    n_tests++; if (rdata !== 8'h0) begin n_fail++; $display("FAIL reset_rdata got=%h exp=0", rdata); end
    n_tests++; if (gnt_id !== 2'd0) begin n_fail++; $display("FAIL reset_gnt_id got=%0d exp=0", gnt_id); end
    n_tests++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy got=%b exp=0", busy); end
    @(posedge clk); #1; rst = 1'b0;
  endtask

  task automatic test_single_read;
    int e, wc; logic [2:0] a; logic [1:0] g; logic [7:0] r;
    do_txn(0, 1'b0, 16'h0010, 8'h00, e, a, g, r, wc);
    n_tests++; if (e !== 3) begin n_fail++; $display("FAIL read_latency got=%0d exp=3", e); end
    n_tests++; if (a !== 3'b001) begin n_fail++; $display("FAIL read_ack got=%b exp=001", a); end
    n_tests++; if (r !== 8'hA5) begin n_fail++; $display("FAIL read_rdata got=%h exp=a5", r); end
    n_tests++; if (busy !== 1'b0) begin n_fail++; $display("FAIL read_idle_busy got=%b exp=0", busy); end
  endtask

  task automatic test_write_read;
    int e, wc; logic [2:0] a; logic [1:0] g; logic [7:0] r;
    do_txn(1, 1'b1, 16'h1234, 8'h3C, e, a, g, r, wc);
    n_tests++; if (a !== 3'b010) begin n_fail++; $display("FAIL wr_ack got=%b exp=010", a); end
    n_tests++; if (wc !== 1) begin n_fail++; $display("FAIL wr_we_cycles got=%0d exp=1", wc); end
    n_tests++; if (r !== 8'hA5) begin n_fail++; $display("FAIL wr_keeps_rdata got=%h exp=a5", r); end
    n_tests++; if (g !== 2'd1) begin n_fail++; $display("FAIL wr_gnt got=%0d exp=1", g); end
    do_txn(1, 1'b0, 16'h1234, 8'h00, e, a, g, r, wc);
    n_tests++; if (r !== 8'h3C) begin n_fail++; $display("FAIL rd_back got=%h exp=3c", r); end
    n_tests++; if (wc !== 0) begin n_fail++; $display("FAIL rd_we_cycles got=%0d exp=0", wc); end
  endtask

  task automatic test_contention;
    logic [1:0] exp_g; logic [7:0] exp_d; logic seen;
    rst = 1'b1; @(posedge clk); #1; rst = 1'b0;
    req_we = '0;
    req_addr = {16'h0300, 16'h0200, 16'h0100};
    req = 3'b111;
    for (int n = 0; n < 6; n++) begin
      exp_g = 2'(n % 3);
      exp_d = (n % 3 == 0) ? 8'h11 : (n % 3 == 1) ? 8'h22 : 8'h33;
      seen = 1'b0;
      for (int k = 0; k < 12 && !seen; k++) begin
        @(posedge clk); @(negedge clk);
        if (ack != 0) seen = 1'b1;
      end
      n_tests++; if (ack !== (3'b001 << exp_g)) begin n_fail++; $display("FAIL rr_ack_%0d got=%b exp=%b", n, ack, 3'b001 << exp_g); end
      n_tests++; if (gnt_id !== exp_g) begin n_fail++; $display("FAIL rr_gnt_%0d got=%0d exp=%0d", n, gnt_id, exp_g); end
      n_tests++; if (rdata !== exp_d) begin n_fail++; $display("FAIL rr_rdata_%0d got=%h exp=%h", n, rdata, exp_d); end
      if (n == 5) req = '0;
    end
    @(posedge clk); #1;
  endtask

  task automatic test_back_to_back;
    int ack_cyc [4]; int na, idle;
    na = 0; idle = 0;
    req_we = '0; req_addr[0 +: AW] = 16'h0040; req = 3'b001;
    for (int cyc = 0; cyc < 40 && na < 4; cyc++) begin
      @(posedge clk); @(negedge clk);
      if (!busy) idle++;
      if (ack[0]) begin
        ack_cyc[na] = cyc;
        n_tests++; if (rdata !== 8'hC0 + 8'(na)) begin n_fail++; $display("FAIL b2b_rdata_%0d got=%h exp=%h", na, rdata, 8'hC0 + 8'(na)); end
        na++;
        req_addr[0 +: AW] = 16'h0040 + 16'(na);
        if (na == 4) req = '0;
      end
    end
    n_tests++; if (na !== 4) begin n_fail++; $display("FAIL b2b_ack_count got=%0d exp=4", na); end
    else begin
      n_tests++; if (ack_cyc[0] !== 2) begin n_fail++; $display("FAIL b2b_first_ack got=%0d exp=2", ack_cyc[0]); end
      for (int i = 1; i < 4; i++) begin
        n_tests++; if (ack_cyc[i] - ack_cyc[i-1] !== 4) begin n_fail++; $display("FAIL b2b_period_%0d got=%0d exp=4", i, ack_cyc[i] - ack_cyc[i-1]); end
      end
    end
    n_tests++; if (idle !== 3) begin n_fail++; $display("FAIL b2b_idle_cycles got=%0d exp=3", idle); end
    @(posedge clk); #1;
  endtask

  task automatic test_rst_capture;
    req_we = '0;
    req_addr[0 +: AW] = 16'h0600; req_addr[AW +: AW] = 16'h0500;
    req = 3'b011;
    @(posedge clk); @(posedge clk); @(negedge clk);
    n_tests++; if (gnt_id !== 2'd1) begin n_fail++; $display("FAIL rstc_pre_gnt got=%0d exp=1", gnt_id); end
    rst = 1'b1;
    @(posedge clk); @(negedge clk);
    n_tests++; if (ack !== 3'b000) begin n_fail++; $display("FAIL rstc_ack got=%b exp=000", ack); end
    n_tests++; if (rdata !== 8'h00) begin n_fail++; $display("FAIL rstc_rdata got=%h exp=00", rdata); end
    n_tests++; if (busy !== 1'b0) begin n_fail++; $display("FAIL rstc_busy got=%b exp=0", busy); end
    rst = 1'b0;
    @(posedge clk); @(negedge clk);
    n_tests++; if (gnt_id !== 2'd0) begin n_fail++; $display("FAIL rstc_next_gnt got=%0d exp=0", gnt_id); end
    n_tests++; if (busy !== 1'b1) begin n_fail++; $display("FAIL rstc_next_busy got=%b exp=1", busy); end
    @(posedge clk); @(posedge clk); @(negedge clk);
    n_tests++; if (ack !== 3'b001) begin n_fail++; $display("FAIL rstc_next_ack got=%b exp=001", ack); end
    n_tests++; if (rdata !== 8'h66) begin n_fail++; $display("FAIL rstc_next_rdata got=%h exp=66", rdata); end
    req = '0;
    @(posedge clk); #1;
  endtask

  task automatic test_lock;
    logic [1:0] exp_g [4];
    logic seen;
`ifdef MEM_ARB_LOCK_EN
    exp_g = '{2'd1, 2'd1, 2'd1, 2'd0};
`else
    exp_g = '{2'd1, 2'd0, 2'd1, 2'd0};
`endif
    rst = 1'b1; @(posedge clk); #1; rst = 1'b0;
    req_we = '0;
    req_addr[0 +: AW] = 16'h0600; req_addr[AW +: AW] = 16'h0500;
    lock = 3'b010; req = 3'b010;
    for (int n = 0; n < 4; n++) begin
      seen = 1'b0;
      for (int k = 0; k < 12 && !seen; k++) begin
        @(posedge clk); @(negedge clk);
        if (ack != 0) seen = 1'b1;
      end
      n_tests++; if (gnt_id !== exp_g[n] || ack !== (3'b001 << exp_g[n])) begin
        n_fail++; $display("FAIL lock_gnt_%0d got=%0d/%b exp=%0d", n, gnt_id, ack, exp_g[n]);
      end
      if (n == 0) req[0] = 1'b1;
      if (n == 2) begin lock = '0; req[1] = 1'b0; end
      if (n == 3) req = '0;
    end
    @(posedge clk); #1;
  endtask

  initial begin
    test_reset();
    test_single_read();
    test_write_read();
    test_contention();
    test_back_to_back();
    test_rst_capture();
    test_lock();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
